// File: rtl/adpll_pkg.sv
// Shared types, default widths and fixed-point helpers for the ADPLL loop filter.
// Helpers work on 32-bit signed values; callers slice results to their width.
package adpll_pkg;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } lock_state_e;

  localparam int DEF_ERROR_WIDTH   = 8;
  localparam int DEF_DCO_CC_WIDTH  = 9;
  localparam int DEF_KP_WIDTH      = 4;
  localparam int DEF_KP_FRAC_WIDTH = 2;
  localparam int DEF_KI_WIDTH      = 6;
  localparam int DEF_KI_FRAC_WIDTH = 5;
  localparam int DEF_ACC_GUARD     = 2;

  localparam int KP_INT_WIDTH = DEF_KP_WIDTH - DEF_KP_FRAC_WIDTH;
  localparam int KI_INT_WIDTH = DEF_KI_WIDTH - DEF_KI_FRAC_WIDTH;
  localparam int ACC_WIDTH    = DEF_DCO_CC_WIDTH + DEF_ACC_GUARD
                              + DEF_KI_FRAC_WIDTH;

  // Clamp x to the range of a w-bit two's-complement number.
  function automatic logic signed [31:0] sat_w(
    input logic signed [31:0] x,
    input int                 w
  );
    logic signed [31:0] mx;
    logic signed [31:0] mn;
    mx = (32'sd1 <<< (w - 1)) - 32'sd1;
    mn = -(32'sd1 <<< (w - 1));
    if (x > mx)      return mx;
    else if (x < mn) return mn;
    else             return x;
  endfunction

  // Add b to a after moving b up by sh fraction bits.
  function automatic logic signed [31:0] add_aligned(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 sh
  );
    return a + (b <<< sh);
  endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock detector: window compare on the S2 error sample plus ACQ/TRACK FSM.
// Ports: clk_i, reset_i (sync, high), e1_i/v1_i (S2 sample), locked_o (registered).
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH  = 8,
  parameter int LOCK_THRESH  = 2,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic signed [ERROR_WIDTH-1:0] e1_i,
  input  logic                          v1_i,
  output logic                          locked_o
);

  localparam int CMAX = (LOCK_COUNT > UNLOCK_COUNT)
                      ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CW   = $clog2(CMAX) + 1;

  lock_state_e        state_q;
  logic [CW-1:0]      cnt_q;
  logic               locked_q;
  logic signed [31:0] e_x;
  logic signed [31:0] mag;
  logic               in_win;

  always_comb begin
    e_x    = 32'(e1_i);
    mag    = (e_x < 32'sd0) ? -e_x : e_x;
    in_win = (mag <= LOCK_THRESH);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ACQ;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else if (v1_i) begin
      unique case (state_q)
        ACQ: begin
          if (!in_win) begin
            cnt_q <= '0;
          end else if (cnt_q == CW'(LOCK_COUNT - 1)) begin
            state_q  <= TRACK;
            cnt_q    <= '0;
            locked_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        TRACK: begin
          if (in_win) begin
            cnt_q <= '0;
          end else if (cnt_q == CW'(UNLOCK_COUNT - 1)) begin
            state_q  <= ACQ;
            cnt_q    <= '0;
            locked_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/pi_loop_filter.sv
// Two-stage PI loop filter with lock-switched gains, saturating integrator
// with anti-windup and clamped output; error in, DCO control code out.
module pi_loop_filter
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH   = DEF_ERROR_WIDTH,
  parameter int DCO_CC_WIDTH  = DEF_DCO_CC_WIDTH,
  parameter int KP_WIDTH      = DEF_KP_WIDTH,
  parameter int KP_FRAC_WIDTH = DEF_KP_FRAC_WIDTH,
  parameter int KI_WIDTH      = DEF_KI_WIDTH,
  parameter int KI_FRAC_WIDTH = DEF_KI_FRAC_WIDTH,
  parameter int ACC_GUARD     = DEF_ACC_GUARD,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4
) (
  input  logic                           gen_clk_i,
  input  logic                           reset_i,
  input  logic                           error_valid_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_i,
  input  logic        [KP_WIDTH-1:0]     kp_acq_i,
  input  logic        [KI_WIDTH-1:0]     ki_acq_i,
  input  logic        [KP_WIDTH-1:0]     kp_trk_i,
  input  logic        [KI_WIDTH-1:0]     ki_trk_i,
  input  logic                           freeze_i,
  output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
  output logic                           dco_cc_valid_o,
  output logic                           locked_o,
  output logic                           sat_o
);

  localparam int ACC_W = DCO_CC_WIDTH + ACC_GUARD + KI_FRAC_WIDTH;
  localparam int ALIGN = KI_FRAC_WIDTH - KP_FRAC_WIDTH;
  localparam logic signed [31:0] OUT_MAX =
    (32'sd1 <<< (DCO_CC_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] OUT_MIN =
    -(32'sd1 <<< (DCO_CC_WIDTH - 1));

  logic signed [ERROR_WIDTH-1:0]  e1_q, e1_d;
  logic                           v1_q, v1_d;
  logic                           frz1_q, frz1_d;
  logic signed [ACC_W-1:0]        integ_q, integ_d;
  logic signed [DCO_CC_WIDTH-1:0] dco_q, dco_d;
  logic                           valid_q, valid_d;
  logic                           sat_q, sat_d;
  logic                           locked;

  logic [KP_WIDTH-1:0] kp_sel;
  logic [KI_WIDTH-1:0] ki_sel;
  logic signed [31:0]  e_x, kp_x, ki_x;
  logic signed [31:0]  p_x, inc_x, cand_x, sum_x, out_x, clip_x;
  logic                clamp_hi, clamp_lo, hold;

  adpll_lock_detect #(
    .ERROR_WIDTH  (ERROR_WIDTH),
    .LOCK_THRESH  (LOCK_THRESH),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_lock (
    .clk_i    (gen_clk_i),
    .reset_i  (reset_i),
    .e1_i     (e1_q),
    .v1_i     (v1_q),
    .locked_o (locked)
  );

  always_comb begin
    v1_d   = error_valid_i;
    e1_d   = error_valid_i ? error_i  : e1_q;
    frz1_d = error_valid_i ? freeze_i : frz1_q;

    kp_sel = locked ? kp_trk_i : kp_acq_i;
    ki_sel = locked ? ki_trk_i : ki_acq_i;

    e_x    = 32'(e1_q);
    kp_x   = 32'(kp_sel);
    ki_x   = 32'(ki_sel);
    p_x    = e_x * kp_x;
    inc_x  = e_x * ki_x;
    cand_x = sat_w(32'(integ_q) + inc_x, ACC_W);
    sum_x  = add_aligned(cand_x, p_x, ALIGN);
    // Arithmetic shift drops the fraction as a floor.
    out_x  = sum_x >>> KI_FRAC_WIDTH;
    clip_x = sat_w(out_x, DCO_CC_WIDTH);

    clamp_hi = (out_x > OUT_MAX);
    clamp_lo = (out_x < OUT_MIN);
    // Stop integrating further into a clamped rail.
    hold = frz1_q
         | (clamp_hi & (inc_x > 32'sd0))
         | (clamp_lo & (inc_x < 32'sd0));

    integ_d = integ_q;
    dco_d   = dco_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    if (v1_q) begin
      dco_d   = clip_x[DCO_CC_WIDTH-1:0];
      sat_d   = clamp_hi | clamp_lo;
      valid_d = 1'b1;
      if (!hold) integ_d = cand_x[ACC_W-1:0];
    end
  end

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      e1_q    <= '0;
      v1_q    <= 1'b0;
      frz1_q  <= 1'b0;
      integ_q <= '0;
      dco_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      e1_q    <= e1_d;
      v1_q    <= v1_d;
      frz1_q  <= frz1_d;
      integ_q <= integ_d;
      dco_q   <= dco_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign dco_cc_o       = dco_q;
  assign dco_cc_valid_o = valid_q;
  assign sat_o          = sat_q;
  assign locked_o       = locked;

endmodule

// File: tb/tb_pi_loop_filter.sv
// Directed self-checking bench for pi_loop_filter.
// Expected values are hand-computed from the fixed-point definition.
module tb_pi_loop_filter;

  logic              gen_clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              error_valid_i = 1'b0;
  logic signed [7:0] error_i = '0;
  logic [3:0]        kp_acq_i = '0;
  logic [5:0]        ki_acq_i = '0;
  logic [3:0]        kp_trk_i = '0;
  logic [5:0]        ki_trk_i = '0;
  logic              freeze_i = 1'b0;
  logic signed [8:0] dco_cc_o;
  logic              dco_cc_valid_o;
  logic              locked_o;
  logic              sat_o;

  int n_chk  = 0;
  int n_fail = 0;

  pi_loop_filter dut (
    .gen_clk_i      (gen_clk_i),
    .reset_i        (reset_i),
    .error_valid_i  (error_valid_i),
    .error_i        (error_i),
    .kp_acq_i       (kp_acq_i),
    .ki_acq_i       (ki_acq_i),
    .kp_trk_i       (kp_trk_i),
    .ki_trk_i       (ki_trk_i),
    .freeze_i       (freeze_i),
    .dco_cc_o       (dco_cc_o),
    .dco_cc_valid_o (dco_cc_valid_o),
    .locked_o       (locked_o),
    .sat_o          (sat_o)
  );

  always #5 gen_clk_i = ~gen_clk_i;

  task automatic step();
    @(posedge gen_clk_i);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    error_valid_i = 1'b0;
    step();
    reset_i = 1'b0;
  endtask

  // One isolated sample; checks the result one edge after capture.
  task automatic send(input int err, input logic frz,
                      input int exp_dco, input logic exp_sat,
                      input string tag);
    error_valid_i = 1'b1;
    error_i = 8'(err);
    freeze_i = frz;
    step();
    error_valid_i = 1'b0;
    freeze_i = 1'b0;
    step();
    check({tag, ".dco"}, dco_cc_o, exp_dco);
    check({tag, ".sat"}, {31'b0, sat_o}, {31'b0, exp_sat});
    check({tag, ".vld"}, {31'b0, dco_cc_valid_o}, 32'sd1);
  endtask

  int exp4 [8] = '{142, 158, 174, 190, 206, 222, 238, 254};

  initial begin
    // Power-on reset
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    check("rst.dco", dco_cc_o, 0);
    check("rst.vld", {31'b0, dco_cc_valid_o}, 0);
    check("rst.sat", {31'b0, sat_o}, 0);
    check("rst.lock", {31'b0, locked_o}, 0);

    // Proportional path, latency and hold
    kp_acq_i = 4'b0100;
    ki_acq_i = 6'd0;
    error_valid_i = 1'b1;
    error_i = 8'sd10;
    step();
    check("t2.lat_vld", {31'b0, dco_cc_valid_o}, 0);
    error_valid_i = 1'b0;
    step();
    check("t2.dco", dco_cc_o, 10);
    check("t2.vld", {31'b0, dco_cc_valid_o}, 1);
    step();
    check("t2.hold_dco", dco_cc_o, 10);
    check("t2.hold_vld", {31'b0, dco_cc_valid_o}, 0);

    // Integral path, back-to-back samples
    kp_acq_i = 4'd0;
    ki_acq_i = 6'b000100;
    error_valid_i = 1'b1;
    error_i = 8'sd8;
    step();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) error_valid_i = 1'b0;
      step();
      check($sformatf("t3.dco%0d", i), dco_cc_o, i);
      check($sformatf("t3.vld%0d", i), {31'b0, dco_cc_valid_o}, 1);
    end

    // Reset mid-stream with a sample in S1
    error_valid_i = 1'b1;
    error_i = 8'sd8;
    step();
    reset_i = 1'b1;
    error_valid_i = 1'b0;
    step();
    reset_i = 1'b0;
    check("t1.dco", dco_cc_o, 0);
    check("t1.vld", {31'b0, dco_cc_valid_o}, 0);
    check("t1.sat", {31'b0, sat_o}, 0);
    check("t1.lock", {31'b0, locked_o}, 0);
    step();
    check("t1.vld2", {31'b0, dco_cc_valid_o}, 0);
    check("t1.dco2", dco_cc_o, 0);

    // Saturation and anti-windup
    kp_acq_i = 4'b0100;
    ki_acq_i = 6'b000100;
    for (int n = 1; n <= 12; n++) begin
      send(127, 1'b0, (n <= 8) ? exp4[n-1] : 255, (n > 8),
           $sformatf("t4.s%0d", n));
    end
    send(-1, 1'b0, 125, 1'b0, "t4.neg");

    // Lock detection
    do_reset();
    kp_acq_i = 4'b0100;
    ki_acq_i = 6'b000100;
    kp_trk_i = 4'b0010;
    ki_trk_i = 6'b000001;
    for (int k = 1; k <= 15; k++) begin
      send(1, 1'b0, (8 + k) / 8, 1'b0, $sformatf("t5.a%0d", k));
      check($sformatf("t5.a%0d.lock", k), {31'b0, locked_o}, 0);
    end
    send(50, 1'b0, 58, 1'b0, "t5.big");
    check("t5.big.lock", {31'b0, locked_o}, 0);
    for (int k = 1; k <= 16; k++) begin
      send(0, 1'b0, 8, 1'b0, $sformatf("t5.z%0d", k));
      check($sformatf("t5.z%0d.lock", k), {31'b0, locked_o},
            (k == 16) ? 1 : 0);
    end
    send(0, 1'b0, 8, 1'b0, "t5.trk0");
    check("t5.trk0.lock", {31'b0, locked_o}, 1);
    send(-20, 1'b0, -3, 1'b0, "t5.u1");
    check("t5.u1.lock", {31'b0, locked_o}, 1);
    send(-20, 1'b0, -4, 1'b0, "t5.u2");
    check("t5.u2.lock", {31'b0, locked_o}, 1);
    send(-20, 1'b0, -4, 1'b0, "t5.u3");
    check("t5.u3.lock", {31'b0, locked_o}, 1);
    send(-20, 1'b0, -5, 1'b0, "t5.u4");
    check("t5.u4.lock", {31'b0, locked_o}, 0);

    // Freeze
    do_reset();
    kp_acq_i = 4'd0;
    ki_acq_i = 6'd32;
    send(20, 1'b0, 20, 1'b0, "t6.load");
    kp_acq_i = 4'b0100;
    ki_acq_i = 6'd0;
    send(5, 1'b1, 25, 1'b0, "t6.frz");
    ki_acq_i = 6'd32;
    send(5, 1'b1, 30, 1'b0, "t6.frz_ki");
    send(0, 1'b0, 20, 1'b0, "t6.after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pi_loop_filter.md
# pi_loop_filter

Second-generation ADPLL loop filter. It takes signed phase/frequency error samples from the TDC/phase detector and produces a signed DCO control code (the DCO control word). It is a PI filter with:
- a valid handshake on its input;
- separate acquisition and tracking gain pairs, switched automatically by an internal lock detector;
- a saturating integrator with anti-windup;
- a saturated output.

It sits between the phase detector and the DCO code decoder, and replaces the fixed-gain, wrap-around filter.

## Interface
- ERROR_WIDTH, 8: signed error sample width.
- DCO_CC_WIDTH, 9: signed output code width.
- KP_WIDTH, 4 / KP_FRAC_WIDTH, 2: unsigned Kp format; Kp = kp/2^KP_FRAC_WIDTH.
- KI_WIDTH, 6 / KI_FRAC_WIDTH, 5: unsigned Ki format; KP_FRAC_WIDTH ≤ KI_FRAC_WIDTH is required.
- ACC_GUARD, 2: integrator integer bits above DCO_CC_WIDTH.
- LOCK_THRESH, 2: lock window. A sample is "in window" when |error| ≤ LOCK_THRESH.
- LOCK_COUNT, 16: consecutive in-window samples required to declare lock.
- UNLOCK_COUNT, 4: consecutive out-of-window samples required to drop lock.

Ports:
- gen_clk_i, in, 1: the single clock.
- reset_i, in, 1: reset, synchronous and active-high.
- error_valid_i, in, 1: error_i is valid this cycle.
- error_i, in, ERROR_WIDTH, signed: error sample.
- kp_acq_i, in, KP_WIDTH: proportional gain used in ACQ.
- ki_acq_i, in, KI_WIDTH: integral gain used in ACQ.
- kp_trk_i, in, KP_WIDTH: proportional gain used in TRACK.
- ki_trk_i, in, KI_WIDTH: integral gain used in TRACK.
- freeze_i, in, 1: holds the integrator; the proportional path still updates.
- dco_cc_o, out, DCO_CC_WIDTH, signed: DCO control code.
- dco_cc_valid_o, out, 1: one-cycle pulse per processed sample.
- locked_o, out, 1: high in TRACK.
- sat_o, out, 1: the last output was clamped.

## Operation
- **Stage 1 (S1):** on an edge with error_valid_i=1, register error_i into e1 and set v1=1; otherwise v1=0.
- **Stage 2 (S2), on edges where v1=1:**
  - Gain selection: ACQ uses the acq gains and TRACK uses the trk gains. The state used is the value held before this edge.
  - p = e1·Kp, full precision, signed × unsigned.
  - i_inc = e1·Ki.
  - integ_cand = integ + i_inc, saturated to the integrator range, which is signed with DCO_CC_WIDTH+ACC_GUARD integer bits and KI_FRAC_WIDTH fraction bits.
  - sum = integ_cand + p, with p aligned to KI_FRAC_WIDTH.
  - out = floor(sum), i.e. the fraction bits are dropped.
  - out is clamped to [−2^(DCO_CC_WIDTH−1), 2^(DCO_CC_WIDTH−1)−1].
  - Register out into dco_cc_o, set sat_o to the clamp result, and pulse dco_cc_valid_o.
- **Integrator update:**
  - Anti-windup: if out clamps high and i_inc > 0, or out clamps low and i_inc < 0, integ keeps its old value.
  - If freeze_i=1 (sampled with e1), integ keeps its old value.
  - Otherwise integ ← integ_cand.
- **Lock FSM (states ACQ, TRACK):** evaluated on S2 edges using e1.
  - ACQ: an in-window sample increments cnt. When cnt reaches LOCK_COUNT−1 and the current sample is in window, go to TRACK and set cnt=0. An out-of-window sample sets cnt=0.
  - TRACK: an out-of-window sample increments cnt. When the UNLOCK_COUNT-th consecutive out-of-window sample arrives, go to ACQ and set cnt=0. An in-window sample sets cnt=0.
  - locked_o is registered, equals (state==TRACK), and updates on the same edge as the state.
- Gain switching is bumpless: the integrator is never cleared on a state change.
- Samples with error_valid_i=0 change nothing in S2. Outputs hold, and dco_cc_valid_o is low.

## Timing
- Reset (synchronous): on the first edge with reset_i=1:
  - dco_cc_o=0, dco_cc_valid_o=0, sat_o=0, locked_o=0;
  - integ=0, state=ACQ, cnt=0, v1=0.
- A reset mid-operation discards any sample in flight in S1.
- Latency: error sampled at edge k gives dco_cc_o and the dco_cc_valid_o pulse after edge k+1.
- Throughput: one sample per cycle; back-to-back valids are fully supported.
- Gain inputs are sampled at the S2 edge and may change at any time.
- freeze_i is sampled at the S1 edge alongside error_i.
- The lock transition caused by sample k takes effect for sample k+1.

## Structure
- Package adpll_pkg holds:
  - the FSM state encoding (ACQ, TRACK);
  - the saturate-to-width and aligned-add helper functions;
  - localparams KP_INT_WIDTH, KI_INT_WIDTH and ACC_WIDTH.
- Sub-module adpll_lock_detect contains the window compare, cnt and the FSM. Its inputs are e1, v1 and reset; its output is locked.

## Test plan
All scenarios use the default parameters.
1. **Reset:** assert reset_i for 1 cycle mid-stream → next cycle all outputs are 0, locked_o=0, and the in-flight sample produces no valid pulse.
2. **Proportional path:** kp_acq=4'b0100 (1.0), ki_acq=0, single sample error=+10 → dco_cc_o=10 with a valid pulse exactly 2 edges after the sample, then holds.
3. **Integral path:** kp=0, ki_acq=6'b000100 (0.125), four back-to-back samples of +8 → outputs 1, 2, 3, 4 on consecutive cycles.
4. **Saturation and anti-windup:**
   - Stimulus: kp=1.0, ki=0.125, error=+127 repeated.
   - Required: dco_cc_o clamps at 255 with sat_o=1, and the integrator stops growing.
   - Then error=−1 → output ≤ 127 and sat_o=0 on the first such sample.
5. **Lock detection:**
   - 15 samples of error=1, then one of error=50 → locked_o stays 0.
   - Then 16 samples of error=0 → locked_o=1 after the 16th.
   - With error=0, dco_cc_o is unchanged across the switch.
   - Then 4 samples of error=−20 → locked_o=0.
6. **Freeze:** integrator at 20, freeze_i=1, kp=1.0, error=+5 → output 25, and integ remains 20 on the following sample of error=0 (output 20).
